leaf_refill_arbiter: RTL and testbench

LEAF_REFILL_ARBITER -- requirements
Module: leaf_refill_arbiter

---
 rtl/leaf_refill_arbiter.sv | 195 +++++++++++++++++++
 tb/tb_leaf_refill_arbiter.sv | 454 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/leaf_refill_arbiter.sv
// Leaf refill arbiter: walks per-leaf run descriptors, issues bounded read bursts into leaf FIFOs and
// finishes each leaf with a zero terminator. Define LEAF_REFILL_RR_EN for round-robin grants (default fixed priority).
module leaf_refill_arbiter #(
  parameter int NUM_LEAVES = 4,
  parameter int BURST_LEN  = 4,
  parameter int ADDR_W     = 32,
  parameter int LEN_W      = 16,
  localparam int LEAF_W    = (NUM_LEAVES > 1) ? $clog2(NUM_LEAVES) : 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_cfg_load,
  input  logic [LEAF_W-1:0]     i_cfg_leaf,
  input  logic [ADDR_W-1:0]     i_cfg_base,
  input  logic [LEN_W-1:0]      i_cfg_len,
  input  logic                  i_start,
  input  logic [NUM_LEAVES-1:0] i_leaf_space_ok,
  input  logic                  i_mem_ready,
  input  logic                  i_mem_rvalid,
  output logic                  o_mem_req,
  output logic [ADDR_W-1:0]     o_mem_addr,
  output logic [4:0]            o_mem_len,
  output logic [NUM_LEAVES-1:0] o_leaf_push,
  output logic                  o_push_zero,
  output logic                  o_busy,
  output logic                  o_all_done,
  output logic                  o_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARB,
    S_REQ,
    S_WAIT_DATA,
    S_TERM,
    S_DONE
  } state_e;

  state_e                  state_q;
  logic [LEAF_W-1:0]       cur_q;
  logic [4:0]              len_q;
  logic [4:0]              beat_q;
  logic                    err_q;
  logic [NUM_LEAVES-1:0]   term_q;
  logic [ADDR_W-1:0]       base_q [NUM_LEAVES];
  logic [LEN_W-1:0]        rem_q  [NUM_LEAVES];

  logic [NUM_LEAVES-1:0]   eligible;
  logic                    grant_vld;
  logic [LEAF_W-1:0]       grant_idx;
  logic [LEN_W-1:0]        grant_rem;
  logic [4:0]              burst_len_d;
  logic [NUM_LEAVES-1:0]   push_d;

  assign eligible = i_leaf_space_ok & ~term_q;

`ifdef LEAF_REFILL_RR_EN
  logic [LEAF_W-1:0] rr_q;
  logic [LEAF_W-1:0] rr_d;
  logic [LEAF_W-1:0] scan_idx;

  // rr_q holds the first index to consider, i.e. the one after the previous grant.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    scan_idx  = '0;
    for (int k = 0; k < NUM_LEAVES; k++) begin
      scan_idx = LEAF_W'((int'(rr_q) + k) % NUM_LEAVES);
      if (!grant_vld && eligible[scan_idx]) begin
        grant_vld = 1'b1;
        grant_idx = scan_idx;
      end
    end
    rr_d = (grant_idx == LEAF_W'(NUM_LEAVES - 1)) ? '0 : grant_idx + 1'b1;
  end
`else
  // Descending scan so the lowest eligible index wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int i = NUM_LEAVES - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        grant_vld = 1'b1;
        grant_idx = LEAF_W'(i);
      end
    end
  end
`endif

  assign grant_rem   = rem_q[grant_idx];
  assign burst_len_d = (grant_rem > LEN_W'(BURST_LEN)) ? 5'(BURST_LEN) : 5'(grant_rem);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      cur_q   <= '0;
      len_q   <= '0;
      beat_q  <= '0;
      err_q   <= 1'b0;
      term_q  <= '0;
`ifdef LEAF_REFILL_RR_EN
      rr_q    <= '0;
`endif
      for (int i = 0; i < NUM_LEAVES; i++) begin
        base_q[i] <= '0;
        rem_q[i]  <= '0;
      end
    end else begin
      // Stray beats (including ones from a burst abandoned by reset) are dropped but flagged.
      if (i_mem_rvalid && (state_q != S_WAIT_DATA)) begin
        err_q <= 1'b1;
      end

      case (state_q)
        S_IDLE: begin
          if (i_cfg_load) begin
            base_q[i_cfg_leaf] <= i_cfg_base;
            rem_q[i_cfg_leaf]  <= i_cfg_len;
            term_q[i_cfg_leaf] <= 1'b0;
          end
          if (i_start) begin
            state_q <= S_ARB;
          end
        end

        S_ARB: begin
          if (grant_vld) begin
            cur_q <= grant_idx;
`ifdef LEAF_REFILL_RR_EN
            rr_q  <= rr_d;
`endif
            if (grant_rem != '0) begin
              len_q   <= burst_len_d;
              state_q <= S_REQ;
            end else begin
              state_q <= S_TERM;
            end
          end else if (&term_q) begin
            state_q <= S_DONE;
          end
        end

        S_REQ: begin
          if (i_mem_ready) begin
            base_q[cur_q] <= base_q[cur_q] + ADDR_W'(len_q);
            rem_q[cur_q]  <= rem_q[cur_q] - LEN_W'(len_q);
            beat_q        <= '0;
            state_q       <= S_WAIT_DATA;
          end
        end

        S_WAIT_DATA: begin
          if (i_mem_rvalid) begin
            beat_q <= beat_q + 5'd1;
            if (beat_q == (len_q - 5'd1)) begin
              state_q <= S_ARB;
            end
          end
        end

        S_TERM: begin
          term_q[cur_q] <= 1'b1;
          state_q       <= S_ARB;
        end

        S_DONE: begin
          if (i_start) begin
            term_q  <= '0;
            state_q <= S_IDLE;
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Data beats pass straight through to the granted leaf in the cycle they arrive.
  always_comb begin
    push_d = '0;
    if ((state_q == S_TERM) || ((state_q == S_WAIT_DATA) && i_mem_rvalid)) begin
      push_d[cur_q] = 1'b1;
    end
  end

  assign o_leaf_push = push_d;
  assign o_push_zero = (state_q == S_TERM);
  assign o_mem_req   = (state_q == S_REQ);
  assign o_mem_addr  = (state_q == S_REQ) ? base_q[cur_q] : '0;
  assign o_mem_len   = (state_q == S_REQ) ? len_q : '0;
  assign o_busy      = (state_q != S_IDLE) && (state_q != S_DONE);
  assign o_all_done  = (state_q == S_DONE);
  assign o_err       = err_q;

endmodule

// File: tb/tb_leaf_refill_arbiter.sv
// Self-checking bench for leaf_refill_arbiter: vector table, transaction-level reference model with
// randomized handshakes, and directed multi-cycle corner cases. Honours LEAF_REFILL_RR_EN like the design.
module tb_leaf_refill_arbiter;
  localparam int N  = 4;
  localparam int BL = 4;
  localparam int AW = 32;
  localparam int LW = 16;

`ifdef LEAF_REFILL_RR_EN
  localparam bit RR_MODE = 1'b1;
`else
  localparam bit RR_MODE = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          i_rst;
  logic          i_cfg_load;
  logic [1:0]    i_cfg_leaf;
  logic [AW-1:0] i_cfg_base;
  logic [LW-1:0] i_cfg_len;
  logic          i_start;
  logic [N-1:0]  i_leaf_space_ok;
  logic          i_mem_ready;
  logic          i_mem_rvalid;
  logic          o_mem_req;
  logic [AW-1:0] o_mem_addr;
  logic [4:0]    o_mem_len;
  logic [N-1:0]  o_leaf_push;
  logic          o_push_zero;
  logic          o_busy;
  logic          o_all_done;
  logic          o_err;

  leaf_refill_arbiter #(
    .NUM_LEAVES(N), .BURST_LEN(BL), .ADDR_W(AW), .LEN_W(LW)
  ) dut (
    .i_clk(clk), .i_rst(i_rst), .i_cfg_load(i_cfg_load), .i_cfg_leaf(i_cfg_leaf),
    .i_cfg_base(i_cfg_base), .i_cfg_len(i_cfg_len), .i_start(i_start),
    .i_leaf_space_ok(i_leaf_space_ok), .i_mem_ready(i_mem_ready), .i_mem_rvalid(i_mem_rvalid),
    .o_mem_req(o_mem_req), .o_mem_addr(o_mem_addr), .o_mem_len(o_mem_len),
    .o_leaf_push(o_leaf_push), .o_push_zero(o_push_zero), .o_busy(o_busy),
    .o_all_done(o_all_done), .o_err(o_err)
  );

  always #5 clk = ~clk;

  int checkCount = 0;
  int failCount  = 0;

  typedef struct {
    bit            isTerm;
    int            leaf;
    logic [AW-1:0] addr;
    int            len;
  } ev_t;

  typedef struct {
    logic         load;
    logic [1:0]   leaf;
    logic [LW-1:0] len;
    logic         start;
    logic         rvalid;
    logic [N-1:0] expPush;
    logic         expZero;
    logic         expReq;
    logic         expBusy;
    logic         expDone;
    logic         expErr;
  } vec_t;

  // Reference model: per-leaf descriptors and the round-robin start index.
  logic [AW-1:0] mBase [N];
  int            mRem  [N];
  int            mPtr;
  ev_t           expQ [$];

  logic [AW-1:0] reqAddrLog [$];
  int            reqLenLog [$];
  int            burstLeafLog [$];
  int            dataCount [N];
  int            termCount [N];

  vec_t vecs [19];

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  function automatic logic [N-1:0] onehot(input int i);
    logic [N-1:0] v;
    v = '0;
    if (i >= 0 && i < N) v[i] = 1'b1;
    return v;
  endfunction

  function automatic int idxOf(input logic [N-1:0] v);
    int r;
    r = -1;
    for (int i = 0; i < N; i++) if (v[i]) r = (r == -1) ? i : -2;
    return r;
  endfunction

  function automatic logic [63:0] allOuts();
    return {o_mem_req, o_mem_addr, o_mem_len, o_leaf_push, o_push_zero, o_busy, o_all_done, o_err};
  endfunction

  function automatic logic [63:0] logAddr(input int k);
    return (k < reqAddrLog.size()) ? 64'(reqAddrLog[k]) : 64'hDEAD_BEEF;
  endfunction

  function automatic int logLen(input int k);
    return (k < reqLenLog.size()) ? reqLenLog[k] : -1;
  endfunction

  function automatic int logLeaf(input int k);
    return (k < burstLeafLog.size()) ? burstLeafLog[k] : -1;
  endfunction

  task automatic modelReset();
    for (int i = 0; i < N; i++) begin
      mBase[i] = '0;
      mRem[i]  = 0;
    end
    mPtr = 0;
    expQ.delete();
  endtask

  // Expand the loaded descriptors into the ordered list of bursts and terminators one refill run produces.
  task automatic buildExpected();
    bit  sent [N];
    int  remaining;
    int  g;
    int  len;
    ev_t ev;
    for (int i = 0; i < N; i++) sent[i] = 1'b0;
    remaining = N;
    while (remaining > 0) begin
      g = -1;
      for (int k = 0; k < N; k++) begin
        int cand;
        cand = RR_MODE ? (mPtr + k) % N : k;
        if (g < 0 && !sent[cand]) g = cand;
      end
      if (RR_MODE) mPtr = (g + 1) % N;
      if (mRem[g] > 0) begin
        len       = (mRem[g] < BL) ? mRem[g] : BL;
        ev.isTerm = 1'b0;
        ev.leaf   = g;
        ev.addr   = mBase[g];
        ev.len    = len;
        expQ.push_back(ev);
        mBase[g]  = mBase[g] + AW'(len);
        mRem[g]   = mRem[g] - len;
      end else begin
        ev.isTerm = 1'b1;
        ev.leaf   = g;
        ev.addr   = '0;
        ev.len    = 0;
        expQ.push_back(ev);
        sent[g]   = 1'b1;
        remaining--;
      end
    end
  endtask

  task automatic clearInputs();
    i_cfg_load      = 1'b0;
    i_cfg_leaf      = '0;
    i_cfg_base      = '0;
    i_cfg_len       = '0;
    i_start         = 1'b0;
    i_leaf_space_ok = '0;
    i_mem_ready     = 1'b0;
    i_mem_rvalid    = 1'b0;
  endtask

  task automatic doReset();
    clearInputs();
    i_rst = 1'b1;
    @(posedge clk); #1;
    checkOutput("reset_outputs", allOuts(), 64'd0);
    @(posedge clk); #1;
    i_rst = 1'b0;
    modelReset();
  endtask

  task automatic loadLeaf(input int leaf, input logic [AW-1:0] base, input int len);
    i_cfg_load = 1'b1;
    i_cfg_leaf = 2'(leaf);
    i_cfg_base = base;
    i_cfg_len  = LW'(len);
    @(posedge clk); #1;
    i_cfg_load = 1'b0;
    mBase[leaf] = base;
    mRem[leaf]  = len;
  endtask

  task automatic startRun();
    i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
  endtask

  task automatic applyStimulus(input vec_t v);
    i_cfg_load      = v.load;
    i_cfg_leaf      = v.leaf;
    i_cfg_base      = {22'd0, v.leaf, 8'h00};
    i_cfg_len       = v.len;
    i_start         = v.start;
    i_mem_rvalid    = v.rvalid;
    i_mem_ready     = 1'b1;
    i_leaf_space_ok = '1;
  endtask

  // Drive one refill run with random handshakes, comparing every request and push against expQ.
  task automatic runRefill(input int maxCycles, input int readyPct, input int validPct, input bit checkErr);
    ev_t           ev;
    int            curLeaf = -1;
    int            curLen = 0;
    int            beatsLeft = 0;
    logic [AW-1:0] curAddr = '0;
    bit            reqSeen = 1'b0;
    bit            gotDone = 1'b0;
    bit            rdyDrv;
    bit            rvDrv;
    int            pushIdx;
    reqAddrLog.delete();
    reqLenLog.delete();
    burstLeafLog.delete();
    for (int i = 0; i < N; i++) begin
      dataCount[i] = 0;
      termCount[i] = 0;
    end
    for (int c = 0; c < maxCycles && !gotDone; c++) begin
      rdyDrv          = ($urandom_range(99) < readyPct);
      rvDrv           = (beatsLeft > 0) && ($urandom_range(99) < validPct);
      i_mem_ready     = rdyDrv;
      i_mem_rvalid    = rvDrv;
      i_leaf_space_ok = ($urandom_range(99) < 80) ? '1 : '0;
      @(negedge clk);
      if (o_mem_req) begin
        if (!reqSeen) begin
          if (expQ.size() == 0 || expQ[0].isTerm) begin
            checkOutput("req_not_in_model", 64'(o_mem_req), 64'd0);
          end else begin
            ev = expQ.pop_front();
            checkOutput("req_addr", 64'(o_mem_addr), 64'(ev.addr));
            checkOutput("req_len", 64'(o_mem_len), 64'(ev.len));
            reqAddrLog.push_back(o_mem_addr);
            reqLenLog.push_back(int'(o_mem_len));
            curLeaf = ev.leaf;
            curLen  = ev.len;
            curAddr = ev.addr;
            reqSeen = 1'b1;
          end
        end else begin
          checkOutput("req_addr_stable", 64'(o_mem_addr), 64'(curAddr));
          checkOutput("req_len_stable", 64'(o_mem_len), 64'(curLen));
        end
        if (rdyDrv && reqSeen) begin
          beatsLeft = curLen;
          reqSeen   = 1'b0;
        end
      end
      if (rvDrv) begin
        pushIdx = idxOf(o_leaf_push);
        if (beatsLeft == curLen) burstLeafLog.push_back(pushIdx);
        if (pushIdx >= 0) dataCount[pushIdx]++;
        checkOutput("data_push", 64'({o_push_zero, o_leaf_push}), 64'({1'b0, onehot(curLeaf)}));
        beatsLeft--;
      end else if (o_leaf_push != '0) begin
        if (expQ.size() > 0 && expQ[0].isTerm) begin
          ev = expQ.pop_front();
          pushIdx = idxOf(o_leaf_push);
          if (pushIdx >= 0) termCount[pushIdx]++;
          checkOutput("term_push", 64'({o_push_zero, o_leaf_push}), 64'({1'b1, onehot(ev.leaf)}));
        end else begin
          checkOutput("push_not_in_model", 64'(o_leaf_push), 64'd0);
        end
      end
      if (o_all_done) gotDone = 1'b1;
      @(posedge clk); #1;
    end
    checkOutput("all_done", 64'(o_all_done), 64'd1);
    checkOutput("events_left", 64'(expQ.size()), 64'd0);
    if (checkErr) checkOutput("err_clean", 64'(o_err), 64'd0);
    expQ.delete();
    i_mem_ready  = 1'b0;
    i_mem_rvalid = 1'b0;
    startRun();
    checkOutput("idle_after_done", 64'({o_busy, o_all_done}), 64'd0);
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int            waited;
    int            expLeaf [4];
    clearInputs();
    i_rst = 1'b1;
    @(posedge clk); #1;
    checkOutput("reset_outputs_initial", allOuts(), 64'd0);
    i_rst = 1'b0;
    modelReset();

    // Zero-length runs on every leaf, then DONE behaviour and a stray beat setting the sticky error.
    vecs[0]  = '{1'b1, 2'd0, 16'd0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 2'd1, 16'd0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 2'd2, 16'd0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 2'd3, 16'd0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 2'd0, 16'd0, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 2'd0, 16'd0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 2'd0, 16'd0, 1'b0, 1'b0, 4'b0001, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 2'd0, 16'd0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 2'd0, 16'd0, 1'b0, 1'b0, 4'b0010, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 2'd0, 16'd0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 2'd0, 16'd0, 1'b0, 1'b0, 4'b0100, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 2'd0, 16'd0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 2'd0, 16'd0, 1'b0, 1'b0, 4'b1000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 2'd0, 16'd0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[14] = '{1'b0, 2'd0, 16'd0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[15] = '{1'b0, 2'd0, 16'd0, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[16] = '{1'b0, 2'd0, 16'd0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[17] = '{1'b0, 2'd0, 16'd0, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[18] = '{1'b0, 2'd0, 16'd0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 19; i++) begin
      applyStimulus(vecs[i]);
      @(negedge clk);
      checkOutput($sformatf("vec%0d", i),
                  64'({o_leaf_push, o_push_zero, o_mem_req, o_busy, o_all_done, o_err}),
                  64'({vecs[i].expPush, vecs[i].expZero, vecs[i].expReq, vecs[i].expBusy,
                       vecs[i].expDone, vecs[i].expErr}));
      @(posedge clk); #1;
    end

    // Randomized descriptors and handshakes against the reference model.
    doReset();
    for (int r = 0; r < 8; r++) begin
      for (int leaf = 0; leaf < N; leaf++) begin
        if ($urandom_range(99) < 70) loadLeaf(leaf, AW'($urandom), int'($urandom_range(11)));
      end
      buildExpected();
      startRun();
      runRefill(3000, 60, 70, 1'b1);
    end

    // Six records on leaf0 from 0x100: one full burst, one short burst, then terminator.
    loadLeaf(0, 32'h100, 6);
    buildExpected();
    startRun();
    runRefill(2000, 100, 100, 1'b1);
    checkOutput("r23_req_count", 64'(reqAddrLog.size()), 64'd2);
    checkOutput("r23_addr0", logAddr(0), 64'h100);
    checkOutput("r23_len0", 64'(logLen(0)), 64'd4);
    checkOutput("r23_addr1", logAddr(1), 64'h104);
    checkOutput("r23_len1", 64'(logLen(1)), 64'd2);
    checkOutput("r23_data_leaf0", 64'(dataCount[0]), 64'd6);
    checkOutput("r23_term_leaf0", 64'(termCount[0]), 64'd1);

    // Two leaves with two bursts each: grant order depends on the arbitration mode.
    doReset();
    loadLeaf(0, 32'h0, 8);
    loadLeaf(1, 32'h1000, 8);
    buildExpected();
    startRun();
    runRefill(2000, 80, 80, 1'b1);
    if (RR_MODE) expLeaf = '{0, 1, 0, 1};
    else         expLeaf = '{0, 0, 1, 1};
    checkOutput("r27_burst_count", 64'(burstLeafLog.size()), 64'd4);
    for (int k = 0; k < 4; k++) begin
      checkOutput($sformatf("r27_grant%0d", k), 64'(logLeaf(k)), 64'(expLeaf[k]));
    end

    // Request held while memory stalls for five cycles.
    doReset();
    i_leaf_space_ok = '1;
    loadLeaf(0, 32'h40, 3);
    buildExpected();
    startRun();
    waited = 0;
    while (!o_mem_req && waited < 10) begin
      @(posedge clk); #1;
      waited++;
    end
    for (int k = 0; k < 5; k++) begin
      checkOutput($sformatf("r25_hold%0d", k), 64'({o_mem_req, o_mem_addr, o_mem_len}),
                  64'({1'b1, 32'h40, 5'd3}));
      @(posedge clk); #1;
    end
    runRefill(2000, 100, 100, 1'b1);

    // A beat while arbitrating is dropped and the error sticks until reset.
    i_leaf_space_ok = '0;
    startRun();
    i_mem_rvalid = 1'b1;
    @(negedge clk);
    checkOutput("r26_no_push", 64'(o_leaf_push), 64'd0);
    checkOutput("r26_busy", 64'(o_busy), 64'd1);
    @(posedge clk); #1;
    i_mem_rvalid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checkOutput($sformatf("r26_err_sticky%0d", k), 64'(o_err), 64'd1);
      @(posedge clk); #1;
    end
    doReset();
    checkOutput("r26_err_cleared", 64'(o_err), 64'd0);

    // Reset after two of four beats: outputs drop at once, descriptors are lost, late beats flag an error.
    i_leaf_space_ok = '1;
    i_mem_ready     = 1'b1;
    loadLeaf(0, 32'h200, 4);
    startRun();
    waited = 0;
    while (!o_mem_req && waited < 10) begin
      @(posedge clk); #1;
      waited++;
    end
    checkOutput("r28_req", 64'(o_mem_req), 64'd1);
    @(posedge clk); #1;
    i_mem_ready  = 1'b0;
    i_mem_rvalid = 1'b1;
    @(negedge clk);
    checkOutput("r28_beat0", 64'(o_leaf_push), 64'b0001);
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("r28_beat1", 64'(o_leaf_push), 64'b0001);
    @(posedge clk); #2;
    i_rst = 1'b1;
    #1;
    checkOutput("r28_reset_outputs", allOuts(), 64'd0);
    @(posedge clk); #1;
    i_rst = 1'b0;
    modelReset();
    @(posedge clk); #1;
    i_mem_rvalid = 1'b0;
    checkOutput("r28_late_beat_err", 64'(o_err), 64'd1);
    buildExpected();
    startRun();
    runRefill(500, 100, 100, 1'b0);
    checkOutput("r28_no_requests", 64'(reqAddrLog.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
